instruction_fetch_block: RTL and testbench



---
 rtl/instruction_fetch_block.sv | 81 ++++++++
 tb/tb_instruction_fetch_block.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_block.sv
// Fetch stage: owns the PC, drives a synchronous instruction ROM and hands
// (ins, current_address) to jump control, inserting a bubble on each redirect.
module instruction_fetch_block #(
  parameter int ADDR_W = 8,
  parameter int INS_W  = 20,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 8'h00,
  parameter logic [INS_W-1:0]  NOP_INS      = 20'h00000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_mux_sel,
  input  logic [ADDR_W-1:0] jmp_loc,
  input  logic              stall,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [INS_W-1:0]  imem_rdata,
  output logic [INS_W-1:0]  ins,
  output logic [ADDR_W-1:0] current_address,
  output logic              ins_valid
);

  typedef enum logic [1:0] {BOOT, RUN, SQUASH} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  // Redirects leave addr_q alone: the data behind it is squashed anyway.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    unique case (state_q)
      BOOT: begin
        addr_d  = pc_q;
        pc_d    = pc_q + 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (pc_mux_sel) begin
          pc_d    = jmp_loc;
          state_d = SQUASH;
        end else if (!stall) begin
          addr_d = pc_q;
          pc_d   = pc_q + 1'b1;
        end
      end
      SQUASH: begin
        if (pc_mux_sel) begin
          pc_d = jmp_loc;
        end else begin
          addr_d  = pc_q;
          pc_d    = pc_q + 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    ins_valid       = (state_q == RUN);
    ins             = ins_valid ? imem_rdata : NOP_INS;
    imem_en         = !(ins_valid && stall && !pc_mux_sel);
    imem_addr       = pc_q;
    current_address = addr_q;
  end

endmodule

// File: tb/tb_instruction_fetch_block.sv
// Directed bench: behavioural sync ROM plus a minimal jump-control stand-in.
module tb_instruction_fetch_block;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_mux_sel;
  logic [7:0]  jmp_loc;
  logic        stall;
  logic [7:0]  imem_addr;
  logic        imem_en;
  logic [19:0] imem_rdata = '0;
  logic [19:0] ins;
  logic [7:0]  current_address;
  logic        ins_valid;

  logic        tb_redir;
  logic [7:0]  tb_jmp;
  logic [19:0] rom [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_block dut (
    .clk(clk), .reset(reset), .pc_mux_sel(pc_mux_sel), .jmp_loc(jmp_loc),
    .stall(stall), .imem_addr(imem_addr), .imem_en(imem_en),
    .imem_rdata(imem_rdata), .ins(ins), .current_address(current_address),
    .ins_valid(ins_valid)
  );

  always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];

  // JMP opcode decoded from the top two bits; bench can also force a redirect
  assign pc_mux_sel = (ins[19:18] == 2'b11) || tb_redir;
  assign jmp_loc    = tb_redir ? tb_jmp : ins[7:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ins(input string tag, input logic [7:0] a, input logic [19:0] d);
    chk({tag, "_vld"}, {31'd0, ins_valid}, 32'd1);
    chk({tag, "_adr"}, {24'd0, current_address}, {24'd0, a});
    chk({tag, "_ins"}, {12'd0, ins}, {12'd0, d});
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_vld"}, {31'd0, ins_valid}, 32'd0);
    chk({tag, "_ins"}, {12'd0, ins}, 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk_bubble(tag);
    chk({tag, "_cur"}, {24'd0, current_address}, 32'd0);
    chk({tag, "_ia"},  {24'd0, imem_addr}, 32'd0);
    chk({tag, "_en"},  {31'd0, imem_en}, 32'd1);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 20'(a);
    rom[5] = 20'hC0040;
    reset = 1'b0; stall = 1'b0; tb_redir = 1'b0; tb_jmp = 8'h00;
    step(); step();
    chk_reset("rst");

    reset = 1'b1;
    #1 chk_reset("boot");
    for (int a = 0; a < 5; a++) begin
      step();
      chk_ins("seq", 8'(a), 20'(a));
    end
    step();
    chk_ins("jmp_src", 8'h05, 20'hC0040);
    chk("jmp_sel", {31'd0, pc_mux_sel}, 32'd1);
    step();
    chk_bubble("jmp_bub");
    step();
    chk_ins("jmp_tgt", 8'h40, 20'h00040);

    tb_redir = 1'b1; tb_jmp = 8'h10;
    step();
    tb_redir = 1'b0;
    chk_bubble("r10_bub");
    step();
    chk_ins("r10", 8'h10, 20'h00010);

    stall = 1'b1;
    #1 chk("stl_en", {31'd0, imem_en}, 32'd0);
    chk_ins("stl1", 8'h10, 20'h00010);
    step();
    chk_ins("stl2", 8'h10, 20'h00010);
    step();
    chk_ins("stl3", 8'h10, 20'h00010);
    stall = 1'b0;
    step();
    chk_ins("stl_nxt", 8'h11, 20'h00011);
    step();
    chk_ins("stl_nxt2", 8'h12, 20'h00012);

    stall = 1'b1; tb_redir = 1'b1; tb_jmp = 8'h20;
    #1 chk("sr_en", {31'd0, imem_en}, 32'd1);
    step();
    stall = 1'b0; tb_redir = 1'b0;
    chk_bubble("sr_bub");
    step();
    chk_ins("sr_tgt", 8'h20, 20'h00020);

    tb_redir = 1'b1; tb_jmp = 8'h30;
    step();
    tb_jmp = 8'hF0;
    chk_bubble("sq_bub1");
    step();
    tb_redir = 1'b0;
    chk_bubble("sq_bub2");
    step();
    chk_ins("sq_tgt", 8'hF0, 20'h000F0);

    tb_redir = 1'b1; tb_jmp = 8'hFE;
    step();
    tb_redir = 1'b0;
    chk_bubble("wr_bub");
    step();
    chk_ins("wr_fe", 8'hFE, 20'h000FE);
    step();
    chk_ins("wr_ff", 8'hFF, 20'h000FF);
    step();
    chk_ins("wr_00", 8'h00, 20'h00000);
    step();
    chk_ins("wr_01", 8'h01, 20'h00001);

    stall = 1'b1;
    step();
    chk_ins("ms_hold", 8'h01, 20'h00001);
    #2 reset = 1'b0;
    #1 chk_reset("ms_rst");
    step();
    chk_reset("ms_rst2");
    reset = 1'b1; stall = 1'b0;
    step();
    chk_ins("rs_00", 8'h00, 20'h00000);
    step();
    chk_ins("rs_01", 8'h01, 20'h00001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
